// File: rtl/deslocamento_circular_direita_if.sv
// Command/data bundle for the right-rotating circular shifter.
`default_nettype none

interface deslocamento_circular_direita_if #(
  parameter int WIDTH = 5,
  parameter int AMT_W = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, amount,
    input  out, busy, done
  );

  modport slave (
    input  load, load_val, start, amount,
    output out, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/deslocamento_circular_direita.sv
// Right-rotating circular shift register: rotates the held value right by
// 'amount' positions, one per clock, then pulses done for a single cycle.
`default_nettype none

module deslocamento_circular_direita #(
  parameter int               WIDTH = 5,
  parameter int               AMT_W = 4,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}}
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  deslocamento_circular_direita_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } state_t;

  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic [AMT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] rot_d;

  assign rot_d = {out_q[0], out_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= INIT;
      cnt_q   <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            out_q <= bus.load_val;
          end else if (bus.start) begin
            cnt_q   <= bus.amount;
            state_q <= ROTATE;
            busy_q  <= 1'b1;
          end
        end
        ROTATE: begin
          // The full count is walked even when it exceeds WIDTH.
          if (cnt_q != CNT_ZERO) begin
            out_q <= rot_d;
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_deslocamento_circular_direita.sv
// Self-checking bench for deslocamento_circular_direita.
`default_nettype none

module tb_deslocamento_circular_direita;
  localparam int W = 5;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  deslocamento_circular_direita_if #(.WIDTH(W), .AMT_W(A)) bus_if ();

  deslocamento_circular_direita #(.WIDTH(W), .AMT_W(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] val;
    logic [A-1:0] amt;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t vecs [7];

  // Rotation by arithmetic: right by n modulo the width.
  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int n);
    int r;
    r = n % W;
    if (r == 0) return v;
    return (v >> r) | (v << (W - r));
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    int r;
    r = n % W;
    if (r == 0) return v;
    return (v << r) | (v >> (W - r));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Load v, rotate by n (optionally with ignored noise during ROTATE) and
  // check every cycle of the command against the timing rules.
  task automatic run_cmd(input logic [W-1:0] v, input int n, input bit noise);
    bus_if.load = 1'b1; bus_if.load_val = v;
    tick();
    bus_if.load = 1'b0;
    chk("load_out", bus_if.out, v);
    bus_if.start = 1'b1; bus_if.amount = n[A-1:0];
    tick();
    bus_if.start = 1'b0;
    chk("start_busy", bus_if.busy, 1);
    chk("start_out", bus_if.out, v);
    for (int i = 1; i <= n; i++) begin
      if (noise) begin
        bus_if.load     = 1'($urandom_range(0, 1));
        bus_if.start    = 1'($urandom_range(0, 1));
        bus_if.load_val = W'($urandom);
        bus_if.amount   = A'($urandom);
      end
      tick();
      chk("rot_out", bus_if.out, rotr(v, i));
      chk("rot_busy_done", {bus_if.busy, bus_if.done}, 2'b10);
    end
    bus_if.load = 1'b0; bus_if.start = 1'b0;
    tick();
    chk("done_pulse", {bus_if.busy, bus_if.done}, 2'b01);
    chk("done_out", bus_if.out, rotr(v, n));
    tick();
    chk("done_clear", {bus_if.busy, bus_if.done}, 2'b00);
  endtask

  initial begin
    logic [W-1:0] v;
    vecs[0] = '{5'b00001, 4'd1,  5'b10000};
    vecs[1] = '{5'b10110, 4'd3,  5'b11010};
    vecs[2] = '{5'b00011, 4'd7,  5'b11000};
    vecs[3] = '{5'b10000, 4'd0,  5'b10000};
    vecs[4] = '{5'b01101, 4'd15, 5'b01101};
    vecs[5] = '{5'b00101, 4'd5,  5'b00101};
    vecs[6] = '{5'b11001, 4'd6,  5'b11100};

    bus_if.load = 1'b0; bus_if.load_val = '0;
    bus_if.start = 1'b0; bus_if.amount = '0;

    // Reset held for two edges, then three idle cycles.
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_state", {bus_if.out, bus_if.busy, bus_if.done}, {5'b11111, 2'b00});
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_state", {bus_if.out, bus_if.busy, bus_if.done}, {5'b11111, 2'b00});
    end

    foreach (vecs[i]) begin
      run_cmd(vecs[i].val, int'(vecs[i].amt), 1'b0);
      chk("table_final", bus_if.out, vecs[i].exp_out);
    end

    // load wins over start in the same cycle.
    bus_if.load = 1'b1; bus_if.load_val = 5'b01010;
    bus_if.start = 1'b1; bus_if.amount = 4'd3;
    tick();
    bus_if.load = 1'b0; bus_if.start = 1'b0;
    chk("prio_out", bus_if.out, 5'b01010);
    chk("prio_busy", bus_if.busy, 0);
    tick();
    chk("prio_hold", {bus_if.out, bus_if.busy, bus_if.done}, {5'b01010, 2'b00});

    // Reset two edges into a 5-step command.
    bus_if.load = 1'b1; bus_if.load_val = 5'b00110;
    tick();
    bus_if.load = 1'b0; bus_if.start = 1'b1; bus_if.amount = 4'd5;
    tick();
    bus_if.start = 1'b0;
    tick();
    chk("midop_rot", bus_if.out, 5'b00011);
    rst = 1'b0;
    tick();
    chk("midop_rst", {bus_if.out, bus_if.busy, bus_if.done}, {5'b11111, 2'b00});
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midop_nodone", {bus_if.out, bus_if.busy, bus_if.done}, {5'b11111, 2'b00});
    end

    // Undoing a left rotation.
    v = 5'b10011;
    run_cmd(rotl(v, 2), 2, 1'b0);
    chk("inverse", bus_if.out, v);

    // Random commands with ignored load/start noise during ROTATE.
    for (int t = 0; t < 25; t++) begin
      v = W'($urandom);
      run_cmd(v, int'($urandom_range(0, 15)), 1'b1);
      chk("rand_ones", $countones(bus_if.out), $countones(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/deslocamento_circular_direita.md
# deslocamento_circular_direita

Right-rotating circular shift register with a command handshake, the counterpart to the team's left-rotating circular shifter. It takes a parallel load value and, on `start`, rotates it right by a requested number of positions, one position per clock, then pulses `done`. It is used to undo a left rotation, so a vector rotated left by N and then right by N comes back unchanged.

## Interface
- `WIDTH`, default 5: register width in bits; must be at least 2.
- `AMT_W`, default 4: width of the rotation-amount field.
- `INIT`, default all ones (5'b11111 at default width): value loaded by reset.
- `clk`  input  1: the single clock; every register updates on the rising edge.
- `rst`  input  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `load`  input  1: parallel load request; honoured only in IDLE.
- `load_val`  input  WIDTH: value written to the register on an honoured `load`.
- `start`  input  1: rotation command; honoured only in IDLE when `load` is 0.
- `amount`  input  AMT_W: number of right rotations; sampled with `start`.
- `out`  output  WIDTH: current register contents (registered).
- `busy`  output  1: high while a command is executing (ROTATE state).
- `done`  output  1: one-cycle pulse marking command completion.

## Operation
- States: IDLE and ROTATE. Internal down-counter `cnt` is AMT_W bits wide.
- Right rotation means `out <= {out[0], out[WIDTH-1:1]}`: bit 0 wraps to the MSB.
- Reset (`rst`=0 at an edge): state goes to IDLE, `out`=INIT, `cnt`=0, `busy`=0, `done`=0. Reset overrides every other input.
- IDLE with `load`=1: `out`<=`load_val`. `start` is ignored in that cycle (load has priority). State stays IDLE.
- IDLE with `start`=1 and `load`=0: `cnt`<=`amount`, state goes to ROTATE, `busy`<=1. `out` is unchanged at that edge.
- IDLE with neither request: `out` holds.
- ROTATE, `cnt`!=0: rotate `out` right by one and decrement `cnt`.
- ROTATE, `cnt`==0: no rotation, state goes to IDLE, `busy`<=0, `done`<=1.
- `load` and `start` during ROTATE are ignored, with no queuing.
- `done` is cleared on every edge where it is not being set, so it is high for exactly one cycle.
- `amount` values at or above WIDTH are legal. The block performs the full count of single-bit rotations; it does not reduce the amount modulo WIDTH.
- Rotation preserves the number of ones in `out`.

## Timing
- `start` sampled at edge k with `amount`=N:
  - `busy` is high after edge k.
  - Rotations happen at edges k+1 through k+N.
  - After edge k+N+1, `busy`=0 and `done`=1.
  - After edge k+N+2, `done`=0.
- Latency from the `start` edge to `done` is N+1 cycles.
- N=0: `busy` is high for one cycle, `done` follows, `out` is unchanged.
- The cycle in which `done`=1 is already IDLE, so a `start` or `load` in that cycle is honoured. Back-to-back commands therefore cost N+2 cycles each.
- `out` always reflects the state after the most recent edge; there are no combinational paths from inputs to outputs.
- Reset asserted mid-ROTATE: at that edge `out`=INIT, `busy`=0, `done`=0, and the command is dropped with no `done` pulse.
- Maximum command length is N=2^AMT_W-1 (15 at defaults), which takes 16 cycles to `done`.

## Test plan
- Reset then idle: hold `rst`=0 for 2 edges, release, wait 3 cycles -> `out`=5'b11111, `busy`=0, `done`=0 on every one of those cycles.
- Single rotation: load 5'b00001, then `start` with `amount`=1 -> `out`=5'b10000 after edge k+1; `done` high exactly during cycle k+2.
- Multi-step: load 5'b10110, `amount`=3 -> `out` steps 01011, 10101, 11010; `busy` high for 4 cycles.
- Wrap past width: load 5'b00011, `amount`=7 -> final `out`=5'b11000 (same as 2 rotations); `done` 8 cycles after `start`.
- Priority and ignore rules:
  - `load`=1 with `load_val`=5'b01010 and `start`=1 in the same cycle -> `out`=01010, `busy` stays 0.
  - `load` or `start` pulsed during ROTATE -> no effect on `out` or `cnt`.
- Reset mid-op and inverse check:
  - `rst`=0 two edges into a 5-step command -> `out`=11111, no `done` pulse.
  - A vector rotated left by 2, then right by 2 with this block -> the original vector.
